// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator.
//   DefWidth      : default bit width of phase and duty values
//   pend_state_e  : duty shadow register state (empty / holding a value)
//   clamp_duty()  : limits a requested duty to the period length
package pwm_pkg;

    localparam int unsigned DefWidth = 8;

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } pend_state_e;

    function automatic int unsigned clamp_duty(input int unsigned duty,
                                               input int unsigned period);
        return (duty > period) ? period : duty;
    endfunction

endpackage

// File: rtl/pwm_gen_if.sv
// Duty-write handshake between a duty source and the PWM generator.
//   duty_in    : requested duty, in ticks high per period
//   duty_valid : duty_in is valid
//   duty_ready : generator can accept a duty write
// master = duty source, slave = pwm_gen.
interface pwm_gen_if
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
);
    logic [WIDTH-1:0] duty_in;
    logic             duty_valid;
    logic             duty_ready;

    modport master (output duty_in, output duty_valid, input duty_ready);
    modport slave  (input duty_in, input duty_valid, output duty_ready);
endinterface

// File: rtl/duty_shadow.sv
// Duty shadow register: holds one pending duty write and hands it to the
// active duty at a period boundary.
//   clk, rst     : clock, synchronous active-low reset
//   wrap_i       : phase is wrapping to 0 on this edge
//   valid_i      : duty write request
//   duty_i       : requested duty (clamped to PERIOD on capture)
//   ready_o      : shadow register is empty and can take a write
//   duty_next_o  : active duty value that will hold after this edge
module duty_shadow
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned PERIOD = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wrap_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] duty_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] duty_next_o
);

    pend_state_e      state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] active_q, active_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StEmpty;
            pend_q   <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            active_q <= active_d;
        end
    end

    // A write accepted on the same edge as a wrap stays pending: it is only
    // captured in StEmpty, and promotion only happens from StFull.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        active_d = active_q;
        unique case (state_q)
            StEmpty: begin
                if (valid_i) begin
                    // duty_i never exceeds 2**WIDTH-1, so the clamped value fits WIDTH
                    pend_d  = WIDTH'(clamp_duty(32'(duty_i), PERIOD));
                    state_d = StFull;
                end
            end
            StFull: begin
                if (wrap_i) begin
                    active_d = pend_q;
                    state_d  = StEmpty;
                end
            end
        endcase
    end

    always_comb begin
        ready_o = (state_q == StEmpty);
    end

    assign duty_next_o = active_d;

endmodule

// File: rtl/pwm_gen.sv
// PWM generator: phase counter advanced by an external tick strobe, with a
// registered glitch-free PWM output and a shadowed duty register that only
// updates at period boundaries.
//   clk, rst   : clock, synchronous active-low reset
//   en         : run enable; low holds phase and forces pwm low
//   tick       : single-cycle advance strobe
//   duty_bus   : duty write handshake (slave side)
//   pwm        : registered PWM output
//   cyc_start  : one-cycle pulse while phase == 0 after a wrap
//   phase      : current phase counter value
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned PERIOD = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tick,
    pwm_gen_if.slave         duty_bus,
    output logic             pwm,
    output logic             cyc_start,
    output logic [WIDTH-1:0] phase
);

    // With PERIOD == 2**WIDTH this is all ones and the +1 wraps naturally.
    localparam logic [WIDTH-1:0] PhaseLast = WIDTH'(PERIOD - 1);

    logic [WIDTH-1:0] phase_q, phase_d;
    logic [WIDTH-1:0] duty_next;
    logic             pwm_q, pwm_d;
    logic             cyc_q;
    logic             adv;
    logic             wrap;

    assign adv  = en & tick;
    assign wrap = adv & (phase_q == PhaseLast);

    duty_shadow #(
        .WIDTH  (WIDTH),
        .PERIOD (PERIOD)
    ) u_duty_shadow (
        .clk         (clk),
        .rst         (rst),
        .wrap_i      (wrap),
        .valid_i     (duty_bus.duty_valid),
        .duty_i      (duty_bus.duty_in),
        .ready_o     (duty_bus.duty_ready),
        .duty_next_o (duty_next)
    );

    always_comb begin
        phase_d = phase_q;
        if (adv) begin
            phase_d = (phase_q == PhaseLast) ? '0 : phase_q + WIDTH'(1);
        end
    end

    // Compare on next-state values so pwm lines up with the phase register.
    assign pwm_d = en & (phase_d < duty_next);

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q <= '0;
            pwm_q   <= 1'b0;
            cyc_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            pwm_q   <= pwm_d;
            cyc_q   <= wrap;
        end
    end

    assign phase     = phase_q;
    assign pwm       = pwm_q;
    assign cyc_start = cyc_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen: a PERIOD=10 instance checked every cycle
// against a behavioural model plus directed sequences, and a PERIOD=256
// instance for the 255-duty boundary.
module tb_pwm_gen;

    localparam int unsigned W  = 8;
    localparam int unsigned PA = 10;
    localparam int unsigned PB = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b0;
    logic         en_a = 1'b0, tick_drv = 1'b0, use_psc = 1'b0;
    logic         tick_a;
    logic         en_b = 1'b0, tick_b = 1'b0;
    logic         pwm_a, cyc_a, pwm_b, cyc_b;
    logic [W-1:0] phase_a, phase_b;

    pwm_gen_if #(.WIDTH(W)) bus_a ();
    pwm_gen_if #(.WIDTH(W)) bus_b ();

    pwm_gen #(.WIDTH(W), .PERIOD(PA)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .en        (en_a),
        .tick      (tick_a),
        .duty_bus  (bus_a),
        .pwm       (pwm_a),
        .cyc_start (cyc_a),
        .phase     (phase_a)
    );

    pwm_gen #(.WIDTH(W), .PERIOD(PB)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .en        (en_b),
        .tick      (tick_b),
        .duty_bus  (bus_b),
        .pwm       (pwm_b),
        .cyc_start (cyc_b),
        .phase     (phase_b)
    );

    // Prescaled counter stand-in: strobe once every 8 clocks.
    logic [2:0] psc_q = 3'd0;
    always @(posedge clk) begin
        if (!use_psc) psc_q <= 3'd0;
        else          psc_q <= psc_q + 3'd1;
    end
    assign tick_a = use_psc ? (psc_q == 3'd7) : tick_drv;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Behavioural model of dut_a: integer phase, queue for the pending duty.
    int  m_phase = 0;
    int  m_active = 0;
    int  m_pend[$];
    bit  m_pwm = 1'b0, m_cyc = 1'b0, m_ready = 1'b1;
    bit  model_on = 1'b0;

    always @(posedge clk) begin
        bit adv, wrap, take;
        if (!rst) begin
            m_phase = 0;
            m_active = 0;
            m_pend.delete();
            m_pwm = 1'b0;
            m_cyc = 1'b0;
            m_ready = 1'b1;
        end else begin
            adv  = en_a && tick_a;
            wrap = adv && (m_phase == PA - 1);
            take = (m_pend.size() == 0) && bus_a.duty_valid;
            if (adv) m_phase = (m_phase + 1) % PA;
            m_cyc = wrap;
            if (wrap && m_pend.size() != 0) m_active = m_pend.pop_front();
            if (take) m_pend.push_back((int'(bus_a.duty_in) > PA) ? PA : int'(bus_a.duty_in));
            m_ready = (m_pend.size() == 0);
            m_pwm = en_a && (m_phase < m_active);
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("model pwm", pwm_a, m_pwm);
            check("model phase", int'(phase_a), m_phase);
            check("model cyc_start", cyc_a, m_cyc);
            check("model duty_ready", bus_a.duty_ready, m_ready);
        end
    end

    task automatic wait_phase_a(input string name, input int v);
        int n = 0;
        @(negedge clk);
        while (int'(phase_a) != v && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, " reach phase"}, int'(phase_a), v);
    endtask

    task automatic wait_cyc_a(input string name);
        int n = 0;
        @(negedge clk);
        while (!cyc_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, " cyc_start seen"}, cyc_a, 1);
    endtask

    // One full period from the cyc_start sample; tick must be every cycle.
    task automatic count_period_a(input string name, input int exp);
        int hi = 0;
        bit shape = 1'b1;
        wait_cyc_a(name);
        for (int i = 0; i < PA; i++) begin
            if (i != 0) @(negedge clk);
            if (pwm_a) hi++;
            if (pwm_a != (int'(phase_a) < exp)) shape = 1'b0;
        end
        check({name, " high ticks"}, hi, exp);
        check({name, " shape"}, shape, 1);
    endtask

    task automatic write_a(input string name, input int d);
        wait_phase_a(name, 2);
        check({name, " ready before write"}, bus_a.duty_ready, 1);
        bus_a.duty_valid = 1'b1;
        bus_a.duty_in = W'(d);
        @(negedge clk);
        bus_a.duty_valid = 1'b0;
    endtask

    typedef struct {
        int duty;
        int exp_high;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   n;
        int   lo;
        int   lo_ph;

        vecs[0] = '{duty: 0,   exp_high: 0};
        vecs[1] = '{duty: 15,  exp_high: 10};
        vecs[2] = '{duty: 10,  exp_high: 10};
        vecs[3] = '{duty: 1,   exp_high: 1};
        vecs[4] = '{duty: 9,   exp_high: 9};
        vecs[5] = '{duty: 255, exp_high: 10};

        bus_b.duty_valid = 1'b0;
        bus_b.duty_in = '0;

        // Reset held with a live write request
        rst = 1'b0;
        en_a = 1'b1;
        tick_drv = 1'b1;
        bus_a.duty_valid = 1'b1;
        bus_a.duty_in = 8'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset pwm", pwm_a, 0);
            check("reset phase", int'(phase_a), 0);
            check("reset duty_ready", bus_a.duty_ready, 1);
            check("reset cyc_start", cyc_a, 0);
        end
        model_on = 1'b1;
        bus_a.duty_valid = 1'b0;
        rst = 1'b1;
        count_period_a("no capture p1", 0);
        count_period_a("no capture p2", 0);

        // Basic duty: write 3 at phase 4
        wait_phase_a("basic", 4);
        bus_a.duty_valid = 1'b1;
        bus_a.duty_in = 8'd3;
        @(negedge clk);
        bus_a.duty_valid = 1'b0;
        check("basic ready low", bus_a.duty_ready, 0);
        n = 0;
        while (!bus_a.duty_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("basic ready back phase", int'(phase_a), 0);
        check("basic ready back cyc", cyc_a, 1);
        count_period_a("basic p1", 3);
        count_period_a("basic p2", 3);

        // Mid-period update; second write while full is dropped
        wait_phase_a("update", 5);
        bus_a.duty_valid = 1'b1;
        bus_a.duty_in = 8'd7;
        @(negedge clk);
        bus_a.duty_in = 8'd9;
        check("update ready low", bus_a.duty_ready, 0);
        check("update current pwm", pwm_a, 0);
        @(negedge clk);
        bus_a.duty_valid = 1'b0;
        count_period_a("update p1", 7);
        count_period_a("update p2", 7);

        // Table: duty boundaries and clamping, three periods each
        foreach (vecs[k]) begin
            write_a($sformatf("vec%0d write", k), vecs[k].duty);
            for (int p = 0; p < 3; p++) begin
                count_period_a($sformatf("vec%0d duty%0d p%0d", k, vecs[k].duty, p),
                               vecs[k].exp_high);
            end
        end

        // PERIOD=256 with duty=255: exactly one low tick, at phase 255
        en_b = 1'b1;
        tick_b = 1'b1;
        bus_b.duty_valid = 1'b1;
        bus_b.duty_in = 8'd255;
        @(negedge clk);
        bus_b.duty_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!cyc_b && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("p256 cyc_start seen", cyc_b, 1);
        lo = 0;
        lo_ph = -1;
        for (int i = 0; i < PB; i++) begin
            if (i != 0) @(negedge clk);
            if (!pwm_b) begin
                lo++;
                lo_ph = int'(phase_b);
            end
        end
        check("p256 low ticks", lo, 1);
        check("p256 low phase", lo_ph, 255);

        // Enable drop under a prescaled tick
        write_a("enable write", 6);
        count_period_a("enable pre", 6);
        use_psc = 1'b1;
        wait_phase_a("enable", 5);
        en_a = 1'b0;
        @(negedge clk);
        check("enable off phase", int'(phase_a), 5);
        check("enable off pwm", pwm_a, 0);
        repeat (24) @(negedge clk);
        check("enable off hold phase", int'(phase_a), 5);
        check("enable off hold pwm", pwm_a, 0);
        en_a = 1'b1;
        n = 0;
        while (int'(phase_a) == 5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("enable resume phase", int'(phase_a), 6);
        use_psc = 1'b0;
        count_period_a("enable post", 6);

        // Reset mid-operation with a pending value
        write_a("midrst active", 4);
        count_period_a("midrst pre", 4);
        write_a("midrst pending", 8);
        wait_phase_a("midrst", 6);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst phase", int'(phase_a), 0);
        check("midrst pwm", pwm_a, 0);
        check("midrst ready", bus_a.duty_ready, 1);
        check("midrst cyc_start", cyc_a, 0);
        for (int p = 0; p < 3; p++) begin
            count_period_a($sformatf("midrst post p%0d", p), 0);
        end

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            en_a = ($urandom_range(0, 9) != 0);
            tick_drv = ($urandom_range(0, 1) != 0);
            bus_a.duty_valid = ($urandom_range(0, 3) == 0);
            bus_a.duty_in = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255))
                                                        : W'($urandom_range(0, 11));
            rst = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        rst = 1'b1;
        bus_a.duty_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
